// File: rtl/scan_seq_ctrl.sv
// scan_seq_ctrl: scan-test sequencer driving load/settle/capture/unload shifts and pattern counting
// Ports: clk, rst (async, active high); test_en, start, pat_total, si_data/si_vld/si_rdy (scan-in
// handshake), chain_so -> so_data/so_vld (registered scan-out), scan_en, shift_en, cap_en (core
// enables), busy, done, pat_cnt, signature (MISR value when SCAN_MISR_EN is defined, else 0).
module scan_seq_ctrl #(
    parameter int NCHAIN    = 8,
    parameter int CHAIN_LEN = 64,
    parameter int CAP_CYC   = 1,
    parameter int PAT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              test_en,
    input  logic              start,
    input  logic [PAT_W-1:0]  pat_total,
    input  logic [NCHAIN-1:0] si_data,
    input  logic              si_vld,
    output logic              si_rdy,
    input  logic [NCHAIN-1:0] chain_so,
    output logic [NCHAIN-1:0] so_data,
    output logic              so_vld,
    output logic              scan_en,
    output logic              shift_en,
    output logic              cap_en,
    output logic              busy,
    output logic              done,
    output logic [PAT_W-1:0]  pat_cnt,
    output logic [15:0]       signature
);
    localparam int CW = $clog2(CHAIN_LEN + 1);
    typedef enum logic [2:0] {IDLE, LOAD, SETTLE, CAPTURE, UNLOAD, DONE} state_t;
    state_t            state_q;
    logic [CW-1:0]     cnt_q;
    logic [1:0]        cap_q;
    logic [PAT_W-1:0]  pat_cnt_q, total_q;
    logic [NCHAIN-1:0] so_data_q;
    logic              so_vld_q;
    logic              shifting, last_shift, last_cap;
    logic [PAT_W-1:0]  pat_next;
    assign shifting   = (state_q == LOAD) || (state_q == UNLOAD);
    assign last_shift = cnt_q == CW'(CHAIN_LEN - 1);
    assign last_cap   = cap_q == 2'(CAP_CYC - 1);
    assign pat_next   = pat_cnt_q + PAT_W'(1);
    // Scan-in data is only a handshake here; the core chains take si_data directly.
    assign si_rdy   = shifting;
    assign scan_en  = shifting;
    assign shift_en = shifting && si_vld;
    assign cap_en   = state_q == CAPTURE;
    assign busy     = state_q != IDLE;
    assign done     = state_q == DONE;
    assign so_data  = so_data_q;
    assign so_vld   = so_vld_q;
    assign pat_cnt  = pat_cnt_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            cap_q     <= '0;
            pat_cnt_q <= '0;
            total_q   <= '0;
            so_data_q <= '0;
            so_vld_q  <= 1'b0;
        end else begin
            so_vld_q <= shift_en;
            if (shift_en) so_data_q <= chain_so;
            if (!test_en) state_q <= IDLE;
            else case (state_q)
                IDLE: if (start) begin
                    total_q   <= pat_total;
                    pat_cnt_q <= '0;
                    cnt_q     <= '0;
                    cap_q     <= '0;
                    state_q   <= pat_total == '0 ? DONE : LOAD;
                end
                LOAD, UNLOAD: if (si_vld) begin
                    cnt_q <= last_shift ? '0 : cnt_q + CW'(1);
                    if (last_shift) state_q <= state_q == LOAD ? SETTLE : DONE;
                end
                SETTLE: state_q <= CAPTURE;
                CAPTURE: begin
                    cap_q <= last_cap ? 2'd0 : cap_q + 2'd1;
                    if (last_cap) begin
                        pat_cnt_q <= pat_next;
                        state_q   <= pat_next < total_q ? LOAD : UNLOAD;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
`ifdef SCAN_MISR_EN
    logic [15:0] misr_q, fold;
    always_comb begin
        fold = '0;
        for (int i = 0; i < NCHAIN; i++) fold[i % 16] = fold[i % 16] ^ so_data_q[i];
    end
    // Updates stop once the FSM is back in IDLE, so the signature is frozen after done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) misr_q <= '0;
        else if (state_q == IDLE && start && test_en) misr_q <= 16'hFFFF;
        else if (state_q != IDLE && so_vld_q)
            misr_q <= {misr_q[14:0], 1'b0} ^ (misr_q[15] ? 16'h1021 : 16'h0000) ^ fold;
    end
    assign signature = misr_q;
`else
    assign signature = 16'h0000;
`endif
endmodule
